// File: rtl/interrupt_controller.sv
// Game Boy interrupt controller: IF/IE registers, IME sequencing and dispatch vector.
// Optional macro INTC_EDGE_DETECT_EN sets IF only on rising edges of i_Request.
module interrupt_controller #(
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
  input  logic        i_Clk,
  input  logic        i_nRst,
  input  logic        i_Enable,
  input  logic [4:0]  i_Request,
  input  logic [15:0] i_Address,
  input  logic [7:0]  i_Data,
  input  logic        i_Write,
  input  logic        i_Read,
  output logic [7:0]  o_Data,
  output logic        o_Selected,
  output logic [4:0]  o_Interrupts,
  input  logic        i_Handle_Interrupt,
  output logic [7:0]  o_Vector,
  output logic        o_Wake,
  input  logic        i_EI,
  input  logic        i_DI,
  input  logic        i_RETI,
  input  logic        i_Instr_Boundary
);

  typedef enum logic [1:0] {
    IME_OFF   = 2'd0,
    IME_ARMED = 2'd1,
    IME_ON    = 2'd2
  } ime_state_t;

  logic [4:0] if_q;
  logic [7:0] ie_q;
  logic [7:0] vector_q;
  ime_state_t ime_state;

  logic       sel_if;
  logic       sel_ie;
  logic       wr_if;
  logic       wr_ie;
  logic       ack;
  logic       ime;
  logic [4:0] pending;
  logic [2:0] ack_idx;
  logic [4:0] ack_mask;
  logic [4:0] set_events;
  logic [4:0] if_next;
  logic [7:0] vector_next;

  assign sel_if  = (i_Address == IF_ADDR);
  assign sel_ie  = (i_Address == IE_ADDR);
  assign wr_if   = i_Write && sel_if;
  assign wr_ie   = i_Write && sel_ie;
  assign ack     = i_Handle_Interrupt;
  assign ime     = (ime_state == IME_ON);
  assign pending = if_q & ie_q[4:0];

`ifdef INTC_EDGE_DETECT_EN
  logic [4:0] req_prev;

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      req_prev <= '0;
    end else if (i_Enable) begin
      req_prev <= i_Request;
    end
  end

  assign set_events = i_Request & ~req_prev;
`else
  assign set_events = i_Request;
`endif

  // Scan from the lowest-priority end so the highest-priority bit wins.
  always_comb begin
    ack_idx = '0;
    for (int unsigned i = 5; i > 0; i--) begin
      if (pending[i-1]) begin
        ack_idx = 3'(i - 1);
      end
    end
  end

  always_comb begin
    ack_mask = '0;
    if (ack && (pending != '0)) begin
      ack_mask = 5'b00001 << ack_idx;
    end
  end

  // Write first, then acknowledge clear, then new requests so none is lost.
  always_comb begin
    if_next = wr_if ? i_Data[4:0] : if_q;
    if_next = if_next & ~ack_mask;
    if_next = if_next | set_events;
  end

  always_comb begin
    vector_next = vector_q;
    if (ack) begin
      vector_next = (pending != '0) ? (8'h40 + {2'b00, ack_idx, 3'b000}) : 8'h00;
    end
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      if_q     <= '0;
      ie_q     <= '0;
      vector_q <= '0;
    end else if (i_Enable) begin
      if_q     <= if_next;
      vector_q <= vector_next;
      if (wr_ie) begin
        ie_q <= i_Data;
      end
    end
  end

  // ARMED is only entered on the EI edge, so any boundary seen while ARMED is a later one.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      ime_state <= IME_OFF;
    end else if (i_Enable) begin
      if (ack || i_DI) begin
        ime_state <= IME_OFF;
      end else begin
        case (ime_state)
          IME_OFF: begin
            if (i_RETI) begin
              ime_state <= IME_ON;
            end else if (i_EI) begin
              ime_state <= IME_ARMED;
            end
          end
          IME_ARMED: begin
            if (i_RETI || i_Instr_Boundary) begin
              ime_state <= IME_ON;
            end
          end
          IME_ON: begin
            ime_state <= IME_ON;
          end
          default: begin
            ime_state <= IME_OFF;
          end
        endcase
      end
    end
  end

  assign o_Interrupts = pending & {5{ime}};
  assign o_Wake       = |pending;
  assign o_Vector     = vector_q;
  assign o_Selected   = i_Read && (sel_if || sel_ie);

  always_comb begin
    o_Data = 8'h00;
    if (i_Read) begin
      if (sel_if) begin
        o_Data = {3'b111, if_q};
      end else if (sel_ie) begin
        o_Data = ie_q;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus randomized traffic against a behavioural model.
module tb_interrupt_controller;

  localparam logic [15:0] A_IF = 16'hFF0F;
  localparam logic [15:0] A_IE = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [4:0]  req = '0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  rdata;
  logic        sel;
  logic [4:0]  intr;
  logic        hdl = 1'b0;
  logic [7:0]  vec;
  logic        wake;
  logic        ei = 1'b0;
  logic        di = 1'b0;
  logic        reti = 1'b0;
  logic        bnd = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  interrupt_controller #(
    .IF_ADDR(16'hFF0F),
    .IE_ADDR(16'hFFFF)
  ) dut (
    .i_Clk(clk),
    .i_nRst(rst_n),
    .i_Enable(en),
    .i_Request(req),
    .i_Address(addr),
    .i_Data(wdata),
    .i_Write(wr),
    .i_Read(rd),
    .o_Data(rdata),
    .o_Selected(sel),
    .o_Interrupts(intr),
    .i_Handle_Interrupt(hdl),
    .o_Vector(vec),
    .o_Wake(wake),
    .i_EI(ei),
    .i_DI(di),
    .i_RETI(reti),
    .i_Instr_Boundary(bnd)
  );

  always #5 clk = ~clk;

  // Behavioural model: IME as an enabled flag plus a pending-EI flag.
  logic [4:0] m_if = '0;
  logic [7:0] m_ie = '0;
  logic [7:0] m_vec = '0;
  logic       m_ime = 1'b0;
  logic       m_arm = 1'b0;
  logic [4:0] m_prev = '0;

  function automatic int lowest(input logic [4:0] p);
    for (int i = 0; i < 5; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic logic [4:0] model_if_next(input logic [4:0] cur, input logic [4:0] pend,
                                               input logic [4:0] prev);
    logic [4:0] r;
    int n;
    r = (wr && addr == A_IF) ? wdata[4:0] : cur;
    n = lowest(pend);
    if (hdl && n >= 0) r[n] = 1'b0;
`ifdef INTC_EDGE_DETECT_EN
    r = r | (req & ~prev);
`else
    r = r | req;
`endif
    return r;
  endfunction

  function automatic logic [7:0] model_vec_next(input logic [7:0] cur, input logic [4:0] pend);
    int n;
    n = lowest(pend);
    if (!hdl) return cur;
    if (n < 0) return 8'h00;
    return 8'(64 + 8 * n);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_if <= '0; m_ie <= '0; m_vec <= '0; m_ime <= 1'b0; m_arm <= 1'b0; m_prev <= '0;
    end else if (en) begin
      m_if   <= model_if_next(m_if, m_if & m_ie[4:0], m_prev);
      m_vec  <= model_vec_next(m_vec, m_if & m_ie[4:0]);
      m_prev <= req;
      if (wr && addr == A_IE) m_ie <= wdata;
      if (hdl || di) begin
        m_ime <= 1'b0; m_arm <= 1'b0;
      end else if (reti) begin
        m_ime <= 1'b1; m_arm <= 1'b0;
      end else if (m_arm && bnd) begin
        m_ime <= 1'b1; m_arm <= 1'b0;
      end else if (ei && !m_ime) begin
        m_arm <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic       e_sel;
    logic [7:0] e_data;
    e_sel  = rd && (addr == A_IF || addr == A_IE);
    e_data = !e_sel ? 8'h00 : (addr == A_IF) ? {3'b111, m_if} : m_ie;
    chk("intr", {3'b000, intr}, {3'b000, m_if & m_ie[4:0] & {5{m_ime}}});
    chk("wake", {7'd0, wake}, {7'd0, |(m_if & m_ie[4:0])});
    chk("vector", vec, m_vec);
    chk("selected", {7'd0, sel}, {7'd0, e_sel});
    chk("rdata", rdata, e_data);
  end

  task automatic tick();
    @(posedge clk);
    #2;
    wr = 1'b0; rd = 1'b0; hdl = 1'b0; ei = 1'b0; di = 1'b0; reti = 1'b0; bnd = 1'b0;
  endtask

  task automatic wreg(input logic [15:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
  endtask

  task automatic rchk(input string name, input logic [15:0] a, input logic [7:0] exp);
    addr = a; rd = 1'b1;
    #1;
    chk(name, rdata, exp);
    rd = 1'b0;
  endtask

  initial begin
    // Reset with requests active.
    req = 5'h1F;
    repeat (3) @(posedge clk);
    #2;
    req = '0;
    rst_n = 1'b1;
    #1;
    rchk("reset_if", A_IF, 8'hE0);
    rchk("reset_ie", A_IE, 8'h00);
    chk("reset_vec", vec, 8'h00);
    chk("reset_intr", {3'b000, intr}, 8'h00);

    // Priority.
    wreg(A_IE, 8'h1F);
    reti = 1'b1; tick();
    req = 5'b10100; tick(); req = '0;
    chk("prio_intr", {3'b000, intr}, 8'h14);
    hdl = 1'b1; tick();
    chk("prio_vec1", vec, 8'h50);
    rchk("prio_if", A_IF, 8'hF0);
    chk("prio_intr_off", {3'b000, intr}, 8'h00);
    reti = 1'b1; tick();
    hdl = 1'b1; tick();
    chk("prio_vec2", vec, 8'h60);

    // EI delay.
    wreg(A_IE, 8'h01);
    req = 5'b00001; tick(); req = '0;
    ei = 1'b1; bnd = 1'b1; tick();
    chk("ei_armed", {3'b000, intr}, 8'h00);
    tick(); tick();
    chk("ei_wait", {3'b000, intr}, 8'h00);
    bnd = 1'b1; tick();
    chk("ei_on", {3'b000, intr}, 8'h01);
    hdl = 1'b1; tick();
    chk("ei_vec", vec, 8'h40);

    // Cancelled dispatch.
    wreg(A_IE, 8'h02);
    req = 5'b00010; tick(); req = '0;
    reti = 1'b1; tick();
    chk("cancel_pre", {3'b000, intr}, 8'h02);
    wreg(A_IE, 8'h00);
    hdl = 1'b1; tick();
    chk("cancel_vec", vec, 8'h00);
    rchk("cancel_if", A_IF, 8'hE2);
    wreg(A_IE, 8'h02);
    chk("cancel_ime", {3'b000, intr}, 8'h00);
    chk("cancel_wake", {7'd0, wake}, 8'h01);

    // Simultaneous ack, IF write and request.
    wreg(A_IE, 8'h1F);
    wreg(A_IF, 8'h01);
    hdl = 1'b1; addr = A_IF; wdata = 8'h00; wr = 1'b1; req = 5'b00001;
    tick(); req = '0;
    rchk("simul_if", A_IF, 8'hE1);
    chk("simul_vec", vec, 8'h40);

    // Held request vs. IF clear.
    wreg(A_IF, 8'h00);
    req = 5'b00100;
    repeat (10) tick();
    wreg(A_IF, 8'h00);
`ifdef INTC_EDGE_DETECT_EN
    rchk("held_req", A_IF, 8'hE0);
`else
    rchk("held_req", A_IF, 8'hE4);
`endif
    req = '0; tick();

    // Clock enable low freezes all state.
    wreg(A_IE, 8'hA5);
    en = 1'b0; addr = A_IE; wdata = 8'h00; wr = 1'b1; hdl = 1'b1; di = 1'b1;
    tick(); tick();
    en = 1'b1;
    rchk("en_ie_hold", A_IE, 8'hA5);
    chk("en_vec_hold", vec, 8'h40);

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 3))
        0: addr = A_IF;
        1: addr = A_IE;
        default: addr = 16'($urandom);
      endcase
      wdata = 8'($urandom);
      wr   = ($urandom_range(0, 7) == 0);
      rd   = $urandom_range(0, 1) == 1;
      for (int b = 0; b < 5; b++) req[b] = ($urandom_range(0, 5) == 0);
      hdl  = ($urandom_range(0, 7) == 0);
      ei   = ($urandom_range(0, 9) == 0);
      di   = ($urandom_range(0, 15) == 0);
      reti = ($urandom_range(0, 15) == 0);
      bnd  = ($urandom_range(0, 3) == 0);
      en   = ($urandom_range(0, 9) != 0);
      if (c == 2000) rst_n = 1'b0;
      if (c == 2003) rst_n = 1'b1;
      @(posedge clk);
      #2;
    end
    req = '0; en = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

- Sits on the CPU side of the Control Unit's interrupt interface.
  - Latches the five Game Boy interrupt requests (VBlank, STAT, Timer, Serial, Joypad) into IF.
  - Masks them with IE and IME, and drives the Control Unit's pending-interrupt input.
- When the Control Unit acknowledges, it:
  - selects the highest-priority pending source,
  - clears that source's IF bit and clears IME,
  - presents the dispatch vector.
- IF (0xFF0F) and IE (0xFFFF) are memory-mapped on the CPU data bus.

## Interface

Parameters:
- IF_ADDR, 16'hFF0F, address of the IF register.
- IE_ADDR, 16'hFFFF, address of the IE register.

Ports:
- i_Clk  in  1  system clock; all state updates on the rising edge.
- i_nRst  in  1  asynchronous, active-low reset.
- i_Enable  in  1  clock enable; when low, no state changes.
- i_Request  in  5  peripheral requests; bit 0 = VBlank (highest priority) … bit 4 = Joypad.
- i_Address  in  16  CPU bus address.
- i_Data  in  8  CPU bus write data.
- i_Write  in  1  register write strobe.
- i_Read  in  1  register read strobe.
- o_Data  out  8  read data; 8'h00 when not selected.
- o_Selected  out  1  high while i_Address matches IF_ADDR or IE_ADDR and i_Read is high.
- o_Interrupts  out  5  IF & IE & {5{IME}}; connects to the Control Unit's i_Interrupts.
- i_Handle_Interrupt  in  1  dispatch acknowledge from the Control Unit (its o_Handle_Interrupt).
- o_Vector  out  8  dispatch address low byte: 8'h40 + 8·n, or 8'h00 if the dispatch was cancelled.
- o_Wake  out  1  |(IF & IE), independent of IME; used for HALT exit.
- i_EI  in  1  EI executed; pulsed in the same cycle as EI's instruction boundary.
- i_DI  in  1  DI executed.
- i_RETI  in  1  RETI executed.
- i_Instr_Boundary  in  1  one-cycle pulse at the last M-cycle of each instruction.

## Operation

**State**
- IF[4:0], IE[7:0], IME, ime_arm, vector register.
- With INTC_EDGE_DETECT_EN, also req_prev[4:0].
- Reset values: all zero. o_Vector = 8'h00, o_Interrupts = 0, o_Wake = 0, o_Data = 8'h00.

**Per enabled clock edge, IF update (in priority order)**
1. CPU write to IF_ADDR loads i_Data[4:0].
2. The acknowledge clear is then applied.
3. New request events are ORed in last.
- Consequences:
  - A request arriving in the same cycle as a write or acknowledge is never lost.
  - An acknowledge clears only the bit it dispatched.

**IE**
- A write to IE_ADDR loads all 8 bits.
- Bits [7:5] are stored and read back but never affect masking.

**Reads (combinational)**
- IF_ADDR returns {3'b111, IF}.
- IE_ADDR returns IE.
- Any other address returns 8'h00 with o_Selected low.

**Acknowledge**
- On i_Handle_Interrupt & i_Enable:
  - n = lowest set index of IF & IE.
  - Clear IF[n], load vector = 8'h40 + {n, 3'b000}, clear IME and ime_arm.
- If IF & IE is zero at the acknowledge (cancelled dispatch): vector = 8'h00, IME still cleared, no IF change.
- IME is ignored at the acknowledge instant. The Control Unit qualified the dispatch earlier.

**IME state machine**
- States: OFF, ARMED, ON.
- OFF:
  - i_EI → ARMED.
  - i_RETI → ON.
- ARMED:
  - next i_Instr_Boundary, in a cycle after the i_EI pulse → ON.
  - i_DI → OFF.
  - acknowledge → OFF.
- ON:
  - i_DI → OFF.
  - acknowledge → OFF.
  - i_EI → stays ON.
- Simultaneous inputs: DI beats EI/RETI; acknowledge beats everything.

## Timing

- All register updates take effect one enabled edge after the strobe.
- o_Interrupts and o_Wake are combinational from the registers, valid the cycle after the update.
- Request to o_Interrupts: 1 edge to latch IF, visible the following cycle.
- Acknowledge to o_Vector valid: 1 edge. o_Vector holds until the next acknowledge.
- Asynchronous reset mid-dispatch:
  - all state returns to reset values immediately;
  - a pending ARMED or in-flight acknowledge is discarded.
- With i_Enable low: no IF set/clear, no IME change, no register writes. req_prev holds its value.

## Configuration

INTC_EDGE_DETECT_EN:
- **Defined:** an IF bit sets only on a 0→1 transition of i_Request (req_prev registered each enabled edge). A level held high sets IF once.
- **Undefined:** an IF bit sets on every enabled edge where the i_Request bit is high.
  - Peripherals must drive single-cycle pulses.
  - No req_prev flops are built.

## Test plan

- **Reset:** hold i_nRst low with requests active → IF=0, IE=0, IME OFF; reading IF_ADDR returns 8'hE0; o_Vector=8'h00.
- **Priority:**
  - Setup: IE=8'h1F, RETI (IME ON), pulse requests 5'b10100.
  - Acknowledge → o_Vector=8'h50 (Timer), IF=5'b10000, o_Interrupts=0.
  - Second acknowledge after RETI → 8'h60.
- **EI delay:**
  - Setup: IE=1, IF=1, pulse i_EI together with i_Instr_Boundary.
  - o_Interrupts stays 0 until the next i_Instr_Boundary; it reads 5'b00001 after that edge.
- **Cancelled dispatch:** write IE=0 in the acknowledge cycle's preceding edge, then acknowledge → o_Vector=8'h00, IME OFF, IF unchanged.
- **Simultaneous events:** in one cycle, acknowledge VBlank (IF bit 0), write IF=8'h00, and raise a VBlank request → IF=5'b00001 afterward, o_Vector=8'h40.
- **Edge detect (macro defined):** hold i_Request[2] high for 10 cycles, clear IF by write → IF bit 2 stays 0. Without the macro, it resets to 1 on the next edge.
